// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} ctrl_state_t;

  typedef enum logic [3:0] {
    I_B, I_BL, I_BLT, I_CBZ, I_ADDI, I_ADDS, I_SUBS, I_BR, I_LDUR, I_STUR, I_ILL
  } instr_t;

  localparam logic [2:0] ALUOP_PASSB = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b011;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;

  localparam logic [4:0]  COND_LT  = 5'b01011;

endpackage

// File: rtl/instr_classify.sv
// Combinational opcode classifier; the narrowest opcode fields are tested first.
module instr_classify
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] opcode,
  output instr_t      cls
);

  logic unusedOpBits;
  assign unusedOpBits = ^opcode[20:5];

  // Only the LT condition is supported; other B.cond encodings are undecodable.
  always_comb begin
    cls = I_ILL;
    if (opcode[31:26] == OP_B)            cls = I_B;
    else if (opcode[31:26] == OP_BL)      cls = I_BL;
    else if (opcode[31:24] == OP_BCOND)   cls = (opcode[4:0] == COND_LT) ? I_BLT : I_ILL;
    else if (opcode[31:24] == OP_CBZ)     cls = I_CBZ;
    else if (opcode[31:22] == OP_ADDI)    cls = I_ADDI;
    else if (opcode[31:21] == OP_ADDS)    cls = I_ADDS;
    else if (opcode[31:21] == OP_SUBS)    cls = I_SUBS;
    else if (opcode[31:21] == OP_BR)      cls = I_BR;
    else if (opcode[31:21] == OP_LDUR)    cls = I_LDUR;
    else if (opcode[31:21] == OP_STUR)    cls = I_STUR;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with handshaked memories,
// NZVC flag register, retired-instruction counter and ack-timeout fault trap.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      opcode,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_c,
  input  logic             db_zero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             ImmSel,
  output logic             UncondBr,
  output logic             BrTaken,
  output logic             LinkSel,
  output logic [2:0]       ALUOp,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             fault
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  ctrl_state_t      state, nextState;
  instr_t           decoded, instr;
  logic [TW-1:0]    waitCnt;
  logic [3:0]       flagReg;
  logic [CNT_W-1:0] retiredReg;
  logic             reqActive, ackSeen, timedOut;
  logic             pcWrite, illegalPulse;

  instr_classify classifier (
    .opcode (opcode),
    .cls    (decoded)
  );

  assign reqActive = (state == FETCH) || (state == MEM);
  assign ackSeen   = ((state == FETCH) && imem_ack) || ((state == MEM) && dmem_ack);
  // An ack on the last allowed cycle still wins over the timeout.
  assign timedOut  = reqActive && !ackSeen && (waitCnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:  if (imem_ack) nextState = DECODE;
              else if (timedOut) nextState = FAULT;
      DECODE: nextState = (decoded == I_ILL) ? FETCH : EXEC;
      EXEC: begin
        case (instr)
          I_ADDI, I_ADDS, I_SUBS: nextState = WB;
          I_LDUR, I_STUR:         nextState = MEM;
          default:                nextState = FETCH;
        endcase
      end
      MEM:    if (dmem_ack) nextState = (instr == I_LDUR) ? WB : FETCH;
              else if (timedOut) nextState = FAULT;
      WB:     nextState = FETCH;
      FAULT:  nextState = FAULT;
      default: nextState = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr      <= I_ILL;
      waitCnt    <= '0;
      flagReg    <= '0;
      retiredReg <= '0;
    end else begin
      if (state == DECODE) instr <= decoded;
      waitCnt <= (reqActive && !ackSeen) ? waitCnt + 1'b1 : '0;
      if ((state == EXEC) && ((instr == I_ADDS) || (instr == I_SUBS)))
        flagReg <= {alu_n, alu_z, alu_v, alu_c};
      if (pcWrite && !illegalPulse) retiredReg <= retiredReg + CNT_W'(1);
    end
  end

  // Every combinational output is forced low while reset is held.
  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    IRWrite      = 1'b0;
    pcWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    Reg2Loc      = 1'b0;
    ALUSrc       = 1'b0;
    MemToReg     = 1'b0;
    ImmSel       = 1'b0;
    UncondBr     = 1'b0;
    BrTaken      = 1'b0;
    LinkSel      = 1'b0;
    ALUOp        = ALUOP_PASSB;
    illegalPulse = 1'b0;
    fault        = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_ack;
        end
        DECODE: begin
          if (decoded == I_ILL) begin
            illegalPulse = 1'b1;
            pcWrite      = 1'b1;
          end
        end
        EXEC: begin
          case (instr)
            I_ADDI: begin
              ALUSrc  = 1'b1;
              ImmSel  = 1'b1;
              ALUOp   = ALUOP_ADD;
              Reg2Loc = 1'b1;
            end
            I_ADDS, I_SUBS: begin
              ALUOp   = (instr == I_SUBS) ? ALUOP_SUB : ALUOP_ADD;
              Reg2Loc = 1'b1;
            end
            I_B, I_BL: begin
              UncondBr = 1'b1;
              BrTaken  = 1'b1;
              pcWrite  = 1'b1;
              RegWrite = (instr == I_BL);
              LinkSel  = (instr == I_BL);
            end
            I_BR: begin
              Reg2Loc = 1'b1;
              BrTaken = 1'b1;
              pcWrite = 1'b1;
            end
            I_CBZ: begin
              BrTaken = db_zero;
              pcWrite = 1'b1;
            end
            I_BLT: begin
              BrTaken = flagReg[3] ^ flagReg[1];
              pcWrite = 1'b1;
            end
            I_LDUR, I_STUR: begin
              ALUSrc = 1'b1;
              ALUOp  = ALUOP_ADD;
            end
            default: ;
          endcase
        end
        MEM: begin
          dmem_req = 1'b1;
          MemWrite = (instr == I_STUR);
          ALUSrc   = 1'b1;
          ALUOp    = ALUOP_ADD;
          pcWrite  = (instr == I_STUR) && dmem_ack;
        end
        WB: begin
          RegWrite = 1'b1;
          pcWrite  = 1'b1;
          MemToReg = (instr == I_LDUR);
        end
        FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign PCWrite = pcWrite;
  assign illegal = illegalPulse;
  assign flags   = flagReg;
  assign retired = retiredReg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: per-instruction expected control traces built from the ISA rules.
module tb_multicycle_control;

  localparam int TMO = 16;
  localparam int K_B = 0, K_BL = 1, K_BLT = 2, K_CBZ = 3, K_ADDI = 4, K_ADDS = 5,
                 K_SUBS = 6, K_BR = 7, K_LDUR = 8, K_STUR = 9, K_ILL = 10, K_BADC = 11;

  logic        clock, reset;
  logic [31:0] opcode;
  logic        alu_n, alu_z, alu_v, alu_c, db_zero;
  logic        imem_req, imem_ack, dmem_req, dmem_ack;
  logic        IRWrite, PCWrite, RegWrite, MemWrite, Reg2Loc, ALUSrc, MemToReg;
  logic        ImmSel, UncondBr, BrTaken, LinkSel, illegal, fault;
  logic [2:0]  ALUOp;
  logic [3:0]  flags;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  logic        eIm, eDm, eIR, ePC, eRW, eMW, eR2L, eSrc, eM2R, eImm, eUnc, eBr, eLink, eIll, eFault;
  logic [2:0]  eOp;
  logic [3:0]  mFlags;
  logic [31:0] mRetired;

  multicycle_control #(.ACK_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .db_zero(db_zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .ImmSel(ImmSel),
    .UncondBr(UncondBr), .BrTaken(BrTaken), .LinkSel(LinkSel), .ALUOp(ALUOp),
    .flags(flags), .retired(retired), .illegal(illegal), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] makeOp(input int kind);
    logic [31:0] op;
    logic [4:0]  cond;
    op = $urandom;
    case (kind)
      K_B:    op[31:26] = 6'b000101;
      K_BL:   op[31:26] = 6'b100101;
      K_BLT:  begin op[31:24] = 8'h54; op[4:0] = 5'b01011; end
      K_CBZ:  op[31:24] = 8'hB4;
      K_ADDI: op[31:22] = 10'b1001000100;
      K_ADDS: op[31:21] = 11'b10101011000;
      K_SUBS: op[31:21] = 11'b11101011000;
      K_BR:   op[31:21] = 11'b11010110000;
      K_LDUR: op[31:21] = 11'b11111000010;
      K_STUR: op[31:21] = 11'b11111000000;
      K_BADC: begin
        cond = 5'($urandom_range(0, 31));
        if (cond == 5'b01011) cond = 5'b00000;
        op[31:24] = 8'h54;
        op[4:0]   = cond;
      end
      default: op = 32'hFFFF_FFFF;
    endcase
    return op;
  endfunction

  task automatic clearExp();
    {eIm, eDm, eIR, ePC, eRW, eMW, eR2L, eSrc, eM2R, eImm, eUnc, eBr, eLink, eIll, eFault} = '0;
    eOp = 3'b000;
  endtask

  task automatic applyStimulus(input logic [31:0] op, input logic iack, input logic dack,
                               input logic [3:0] alu, input logic dbz);
    opcode = op;
    imem_ack = iack;
    dmem_ack = dack;
    {alu_n, alu_z, alu_v, alu_c} = alu;
    db_zero = dbz;
  endtask

  task automatic checkOutput(input string tag);
    logic [17:0] obs, exp;
    obs = {imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, Reg2Loc, ALUSrc, MemToReg,
           ImmSel, UncondBr, BrTaken, LinkSel, ALUOp, illegal, fault};
    exp = {eIm, eDm, eIR, ePC, eRW, eMW, eR2L, eSrc, eM2R, eImm, eUnc, eBr, eLink, eOp, eIll, eFault};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s ctrl observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (flags === mFlags) else begin
      errors++;
      $error("[TB] FAIL %s flags observed=%b expected=%b", tag, flags, mFlags);
    end
    checks++;
    assert (retired === mRetired) else begin
      errors++;
      $error("[TB] FAIL %s retired observed=%0d expected=%0d", tag, retired, mRetired);
    end
  endtask

  // Trapped controller: only fault is high, whatever the acks do.
  task automatic faultPhase(input logic [31:0] op);
    repeat (3) begin
      clearExp();
      eFault = 1'b1;
      applyStimulus(op, rbit(), rbit(), 4'($urandom), rbit());
      #1 checkOutput("fault");
      @(negedge clock);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus($urandom, 1'b1, 1'b1, 4'hF, 1'b1);
    mFlags = 4'h0;
    mRetired = 32'd0;
    clearExp();
    #1 checkOutput("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH until the controller is back in FETCH (or trapped/reset).
  task automatic runInstr(input int kind, input int iw, input int dw, input logic [3:0] alu,
                          input logic dbz, input bit abortMem);
    logic [31:0] op;
    bit isLd, isSt, isIll;
    op = makeOp(kind);
    isLd = (kind == K_LDUR);
    isSt = (kind == K_STUR);
    isIll = (kind >= K_ILL);

    for (int w = 0; w <= iw; w++) begin
      if (w == TMO) begin
        faultPhase(op);
        return;
      end
      clearExp();
      eIm = 1'b1;
      eIR = (w == iw);
      applyStimulus(op, w == iw, rbit(), alu, dbz);
      #1 checkOutput("fetch");
      @(negedge clock);
    end

    clearExp();
    if (isIll) begin
      eIll = 1'b1;
      ePC = 1'b1;
    end
    applyStimulus(op, rbit(), rbit(), alu, dbz);
    #1 checkOutput("decode");
    @(negedge clock);
    if (isIll) return;

    clearExp();
    case (kind)
      K_B:    begin eUnc = 1'b1; eBr = 1'b1; ePC = 1'b1; end
      K_BL:   begin eUnc = 1'b1; eBr = 1'b1; ePC = 1'b1; eRW = 1'b1; eLink = 1'b1; end
      K_BLT:  begin eBr = mFlags[3] ^ mFlags[1]; ePC = 1'b1; end
      K_CBZ:  begin eBr = dbz; ePC = 1'b1; end
      K_ADDI: begin eSrc = 1'b1; eImm = 1'b1; eOp = 3'b010; eR2L = 1'b1; end
      K_ADDS: begin eOp = 3'b010; eR2L = 1'b1; end
      K_SUBS: begin eOp = 3'b011; eR2L = 1'b1; end
      K_BR:   begin eR2L = 1'b1; eBr = 1'b1; ePC = 1'b1; end
      default: begin eSrc = 1'b1; eOp = 3'b010; end
    endcase
    applyStimulus(op, rbit(), rbit(), alu, dbz);
    #1 checkOutput("exec");
    @(negedge clock);
    if (kind == K_ADDS || kind == K_SUBS) mFlags = alu;
    if (ePC) begin
      mRetired = mRetired + 1;
      return;
    end

    if (isLd || isSt) begin
      for (int w = 0; w <= dw; w++) begin
        if (w == TMO) begin
          faultPhase(op);
          return;
        end
        clearExp();
        eDm = 1'b1;
        eMW = isSt;
        eSrc = 1'b1;
        eOp = 3'b010;
        ePC = isSt && (w == dw);
        applyStimulus(op, rbit(), (w == dw) && !abortMem, alu, dbz);
        #1 checkOutput("mem");
        if (abortMem) begin
          #2 reset = 1'b1;
          mFlags = 4'h0;
          mRetired = 32'd0;
          clearExp();
          #1 checkOutput("resetMidMem");
          @(negedge clock);
          reset = 1'b0;
          return;
        end
        @(negedge clock);
        if (ePC) mRetired = mRetired + 1;
      end
      if (isSt) return;
    end

    clearExp();
    eRW = 1'b1;
    ePC = 1'b1;
    eM2R = isLd;
    applyStimulus(op, rbit(), rbit(), alu, dbz);
    #1 checkOutput("wb");
    @(negedge clock);
    mRetired = mRetired + 1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(32'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    mFlags = 4'h0;
    mRetired = 32'd0;
    #2 reset = 1'b1;
    clearExp();
    #2 checkOutput("powerOnReset");
    @(negedge clock);
    reset = 1'b0;

    runInstr(K_ADDI, 0, 0, 4'h0, 1'b0, 1'b0);
    runInstr(K_SUBS, 0, 0, 4'b0100, 1'b0, 1'b0);
    runInstr(K_BLT, 1, 0, 4'h0, 1'b0, 1'b0);
    runInstr(K_SUBS, 2, 0, 4'b1000, 1'b0, 1'b0);
    runInstr(K_BLT, 0, 0, 4'h0, 1'b0, 1'b0);
    runInstr(K_LDUR, 0, 3, 4'h0, 1'b0, 1'b0);
    runInstr(K_STUR, 0, 1, 4'h0, 1'b0, 1'b0);
    runInstr(K_ILL, 0, 0, 4'h0, 1'b0, 1'b0);
    runInstr(K_BL, 0, 0, 4'h0, 1'b0, 1'b0);
    runInstr(K_BADC, 0, 0, 4'h0, 1'b0, 1'b0);
    runInstr(K_CBZ, 0, 0, 4'h0, 1'b1, 1'b0);
    runInstr(K_ADDS, TMO - 1, 0, 4'b0011, 1'b0, 1'b0);
    runInstr(K_LDUR, 0, TMO - 1, 4'h0, 1'b0, 1'b0);

    runInstr(K_ADDI, TMO + 4, 0, 4'h0, 1'b0, 1'b0);
    doReset();
    runInstr(K_SUBS, 0, 0, 4'b1010, 1'b0, 1'b0);
    runInstr(K_STUR, 0, TMO + 4, 4'h0, 1'b0, 1'b0);
    doReset();

    runInstr(K_SUBS, 0, 0, 4'b1001, 1'b0, 1'b0);
    runInstr(K_LDUR, 0, 5, 4'h0, 1'b0, 1'b1);

    for (int i = 0; i < 80; i++) begin
      runInstr($urandom_range(0, 11), $urandom_range(0, 4), $urandom_range(0, 4),
               4'($urandom), rbit(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
